mul_issue_stage: RTL

Two-stage pipelined wrapper that sits directly upstream of `SignedMultiplier32`.

- Accepts RISC-V M-extension multiply requests from execute with a valid/ready handshake.
- Registers the operands and drives them into the combinational signed multiplier.
- Applies the unsigned/mixed-sign high-word correction to the 64-bit product.
- Returns a 32-bit result plus destination tag to writeback with backpressure.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_hi_correct.sv | 41 ++++
 rtl/mul_issue_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiply issue stage.
//   mul_op_t     - RISC-V M-extension multiply op select (2 bits)
//   MUL_RES_W    - result word width
//   MUL_PROD_W   - full signed product width from SignedMultiplier32
package mul_pkg;

    localparam int unsigned MUL_RES_W  = 32;
    localparam int unsigned MUL_PROD_W = 2 * MUL_RES_W;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_t;

endpackage : mul_pkg

// File: rtl/mul_hi_correct.sv
// mul_hi_correct: turns the signed 64-bit product into the 32-bit result
// for the requested op, correcting the high word for unsigned operands.
// Ports:
//   i_op        - op select
//   i_a, i_b    - original rs1/rs2 operands
//   i_product   - signed product of i_a * i_b
//   o_result_c  - selected/corrected result (combinational)
module mul_hi_correct
    import mul_pkg::*;
(
    input  mul_op_t                 i_op,
    input  logic [MUL_RES_W-1:0]    i_a,
    input  logic [MUL_RES_W-1:0]    i_b,
    input  logic [MUL_PROD_W-1:0]   i_product,
    output logic [MUL_RES_W-1:0]    o_result_c
);

    logic [MUL_RES_W-1:0] w_hi;
    logic [MUL_RES_W-1:0] w_lo;
    logic [MUL_RES_W-1:0] w_fix_b;
    logic [MUL_RES_W-1:0] w_fix_a;

    assign w_hi = i_product[MUL_PROD_W-1:MUL_RES_W];
    assign w_lo = i_product[MUL_RES_W-1:0];

    // Reading an operand as unsigned adds 2^32 * (other operand) when its
    // sign bit is set; only the high word sees that term.
    assign w_fix_b = i_b[MUL_RES_W-1] ? i_a : '0;
    assign w_fix_a = i_a[MUL_RES_W-1] ? i_b : '0;

    always_comb begin
        o_result_c = w_hi;
        case (i_op)
            MUL_OP_MUL:    o_result_c = w_lo;
            MUL_OP_MULH:   o_result_c = w_hi;
            MUL_OP_MULHSU: o_result_c = w_hi + w_fix_b;
            MUL_OP_MULHU:  o_result_c = w_hi + w_fix_a + w_fix_b;
        endcase
    end

endmodule : mul_hi_correct

// File: rtl/mul_issue_stage.sv
// mul_issue_stage: two-stage pipeline wrapped around an external
// combinational SignedMultiplier32 (instantiated by the parent).
//   S1 registers the request and drives mul_a/mul_b; S2 registers the
//   corrected result and drives rsp_*.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - pipeline flush (only when MUL_FLUSH_EN is defined)
//   req_valid/ready     - request handshake; req_op, req_a, req_b, req_tag
//   mul_a, mul_b        - operands to SignedMultiplier32 (from S1)
//   mul_product         - signed product from SignedMultiplier32
//   rsp_valid/ready     - response handshake; rsp_result, rsp_tag
//   busy                - any stage holds a valid operation
// Configuration macro: MUL_FLUSH_EN adds the flush input.
module mul_issue_stage
    import mul_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef MUL_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [MUL_RES_W-1:0]    req_a,
    input  logic [MUL_RES_W-1:0]    req_b,
    input  logic [TAG_W-1:0]        req_tag,
    output logic [MUL_RES_W-1:0]    mul_a,
    output logic [MUL_RES_W-1:0]    mul_b,
    input  logic [MUL_PROD_W-1:0]   mul_product,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [MUL_RES_W-1:0]    rsp_result,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic                    busy
);

    logic                   r_s1_valid;
    mul_op_t                r_s1_op;
    logic [MUL_RES_W-1:0]   r_s1_a;
    logic [MUL_RES_W-1:0]   r_s1_b;
    logic [TAG_W-1:0]       r_s1_tag;

    logic                   r_s2_valid;
    logic [MUL_RES_W-1:0]   r_s2_result;
    logic [TAG_W-1:0]       r_s2_tag;

    logic                   w_s1_adv;
    logic                   w_s2_adv;
    logic                   w_flush;
    logic [MUL_RES_W-1:0]   w_result;

`ifdef MUL_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Each stage moves when it is empty or its consumer is taking its content.
    assign w_s2_adv  = !r_s2_valid || rsp_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign req_ready = w_s1_adv && !w_flush;

    mul_hi_correct u_hi_correct (
        .i_op       (r_s1_op),
        .i_a        (r_s1_a),
        .i_b        (r_s1_b),
        .i_product  (mul_product),
        .o_result_c (w_result)
    );

    // Pipeline registers; flush drops valids but leaves data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= MUL_OP_MUL;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_tag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_tag    <= '0;
        end else if (w_flush) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid  <= r_s1_valid;
                r_s2_result <= w_result;
                r_s2_tag    <= r_s1_tag;
            end
            if (w_s1_adv) begin
                r_s1_valid  <= req_valid;
                r_s1_op     <= mul_op_t'(req_op);
                r_s1_a      <= req_a;
                r_s1_b      <= req_b;
                r_s1_tag    <= req_tag;
            end
        end
    end

    assign mul_a      = r_s1_a;
    assign mul_b      = r_s1_b;
    assign rsp_valid  = r_s2_valid;
    assign rsp_result = r_s2_result;
    assign rsp_tag    = r_s2_tag;
    assign busy       = r_s1_valid || r_s2_valid;

endmodule : mul_issue_stage
